// File: rtl/sram_arb_pkg.sv
// Shared definitions for the two-port asynchronous SRAM arbiter:
// FSM state encoding and requester port identifiers.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACTIVE = 2'd2,
    HOLD   = 2'd3
  } arb_state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // The port that did not receive the previous grant.
  function automatic logic other_port(input logic port);
    return (port == PORT_A) ? PORT_B : PORT_A;
  endfunction

endpackage

// File: rtl/sram_arb_rr.sv
// Two-way round-robin picker: a lone requester wins outright, a tie goes to
// the port that was not granted last.
module sram_arb_rr
  import sram_arb_pkg::*;
(
  input  logic a_req,
  input  logic b_req,
  input  logic last_grant,
  output logic grant,
  output logic any_req
);

  // Purely combinational pick; the caller registers the decision.
  always_comb begin
    any_req = a_req | b_req;
    if (a_req && b_req) begin
      grant = other_port(last_grant);
    end else if (a_req) begin
      grant = PORT_A;
    end else begin
      grant = PORT_B;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one asynchronous SRAM between a CPU port (A) and a video/DMA port (B).
// Each access runs IDLE -> SETUP -> ACTIVE (N cycles) -> HOLD, so address,
// chip enables and write data bracket every OEn/WEn pulse by one cycle.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int RD_CYCLES  = 3,
  parameter int WR_CYCLES  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_ack,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_ack,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic                  sram_ce1n,
  output logic                  sram_ce2,
  output logic                  sram_oen,
  output logic                  sram_wen,
  output logic [DATA_WIDTH-1:0] sram_dout,
  output logic                  sram_dout_oe,
  input  logic [DATA_WIDTH-1:0] sram_din
);

  localparam int MAX_CYCLES = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYCLES - 1);

  arb_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             cur_port;
  logic             cur_we;
  logic             last_grant;

  logic                  grant;
  logic                  any_req;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  sram_arb_rr u_rr (
    .a_req      (a_req),
    .b_req      (b_req),
    .last_grant (last_grant),
    .grant      (grant),
    .any_req    (any_req)
  );

  // Route the winning port's request fields toward the latch in IDLE.
  always_comb begin
    if (grant == PORT_A) begin
      sel_we    = a_we;
      sel_addr  = a_addr;
      sel_wdata = a_wdata;
    end else begin
      sel_we    = b_we;
      sel_addr  = b_addr;
      sel_wdata = b_wdata;
    end
  end

  // Access sequencer: state, strobe counter and every registered SRAM/port output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      cur_port     <= PORT_A;
      cur_we       <= 1'b0;
      last_grant   <= PORT_B;
      a_ack        <= 1'b0;
      b_ack        <= 1'b0;
      a_rdata      <= '0;
      b_rdata      <= '0;
      sram_addr    <= '0;
      sram_ce1n    <= 1'b1;
      sram_ce2     <= 1'b0;
      sram_oen     <= 1'b1;
      sram_wen     <= 1'b1;
      sram_dout    <= '0;
      sram_dout_oe <= 1'b0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state        <= SETUP;
            cur_port     <= grant;
            last_grant   <= grant;
            cur_we       <= sel_we;
            sram_addr    <= sel_addr;
            sram_ce1n    <= 1'b0;
            sram_ce2     <= 1'b1;
            sram_dout_oe <= sel_we;
            cnt          <= sel_we ? WR_LOAD : RD_LOAD;
            if (sel_we) begin
              sram_dout <= sel_wdata;
            end
          end
        end
        SETUP: begin
          state <= ACTIVE;
          if (cur_we) begin
            sram_wen <= 1'b0;
          end else begin
            sram_oen <= 1'b0;
          end
        end
        ACTIVE: begin
          if (cnt == '0) begin
            state    <= HOLD;
            sram_oen <= 1'b1;
            sram_wen <= 1'b1;
            // Data bus is sampled on the edge that closes the last OEn-low cycle.
            if (!cur_we) begin
              if (cur_port == PORT_A) begin
                a_rdata <= sram_din;
              end else begin
                b_rdata <= sram_din;
              end
            end
            if (cur_port == PORT_A) begin
              a_ack <= 1'b1;
            end else begin
              b_ack <= 1'b1;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        HOLD: begin
          state        <= IDLE;
          sram_ce1n    <= 1'b1;
          sram_ce2     <= 1'b0;
          sram_dout_oe <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: asynchronous SRAM model with 25 ns access
// delay, per-port scoreboards fed by a memory reference model, and a bus
// protocol monitor.
`timescale 1ns/1ps
module tb_sram_port_arbiter;

  localparam int AW = 10;
  localparam int DW = 8;
  localparam int RD = 3;
  localparam int WR = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          a_req = 1'b0, a_we = 1'b0, a_ack;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_wdata = '0, a_rdata;
  logic          b_req = 1'b0, b_we = 1'b0, b_ack;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_wdata = '0, b_rdata;
  logic [AW-1:0] sram_addr;
  logic          sram_ce1n, sram_ce2, sram_oen, sram_wen, sram_dout_oe;
  logic [DW-1:0] sram_dout, sram_din;

  sram_port_arbiter #(
    .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .RD_CYCLES (RD), .WR_CYCLES (WR)
  ) dut (
    .clk (clk), .reset (reset),
    .a_req (a_req), .a_we (a_we), .a_addr (a_addr), .a_wdata (a_wdata),
    .a_ack (a_ack), .a_rdata (a_rdata),
    .b_req (b_req), .b_we (b_we), .b_addr (b_addr), .b_wdata (b_wdata),
    .b_ack (b_ack), .b_rdata (b_rdata),
    .sram_addr (sram_addr), .sram_ce1n (sram_ce1n), .sram_ce2 (sram_ce2),
    .sram_oen (sram_oen), .sram_wen (sram_wen), .sram_dout (sram_dout),
    .sram_dout_oe (sram_dout_oe), .sram_din (sram_din)
  );

  // 48 MHz clock
  always #10.417 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_val(input int i);
    return DW'((i * 37) ^ (i >> 2) ^ 8'h5C);
  endfunction

  // ---------------- asynchronous SRAM model ----------------
  logic [DW-1:0] sram_mem [0:(1<<AW)-1];
  logic          sram_rd_en;
  assign sram_rd_en = !sram_ce1n && sram_ce2 && !sram_oen && sram_wen;
  assign #25 sram_din = sram_rd_en ? sram_mem[sram_addr] : '0;

  initial begin
    for (int i = 0; i < (1 << AW); i++) sram_mem[i] = init_val(i);
    forever begin
      @(posedge sram_wen);
      if (!sram_ce1n && sram_ce2 && sram_dout_oe) sram_mem[sram_addr] = sram_dout;
    end
  end

  // ---------------- counters and helpers ----------------
  int n_chk = 0;
  int n_fail = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endfunction

  // ---------------- reference model and scoreboard ----------------
  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  txn_t exp_a_q[$];
  txn_t exp_b_q[$];
  int   ack_port[$];
  int   ack_cyc[$];

  // A port has at most one access outstanding, so the memory image at issue
  // time is what its read must return (ports touch disjoint written regions).
  function automatic txn_t model_issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    txn_t t;
    t.we   = we;
    t.addr = addr;
    if (we) begin
      ref_mem[addr] = data;
      t.data = data;
    end else begin
      t.data = ref_mem[addr];
    end
    return t;
  endfunction

  task automatic access(input int p, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, input int exp_lat);
    txn_t t;
    int   t0;
    bit   got;
    @(negedge clk);
    t = model_issue(we, addr, data);
    if (p == 0) begin
      exp_a_q.push_back(t);
      a_we = we; a_addr = addr; a_wdata = data; a_req = 1'b1;
    end else begin
      exp_b_q.push_back(t);
      b_we = we; b_addr = addr; b_wdata = data; b_req = 1'b1;
    end
    t0  = cyc;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if ((p == 0 && a_ack) || (p == 1 && b_ack)) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_now(p == 0 ? "a_ack_timeout" : "b_ack_timeout");
    else if (exp_lat > 0) check(p == 0 ? "a_latency" : "b_latency", 32'(cyc - t0), 32'(exp_lat));
    @(negedge clk);
    if (p == 0) a_req = 1'b0; else b_req = 1'b0;
  endtask

  task automatic rand_port(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      logic          we;
      logic [AW-1:0] ad;
      logic [DW-1:0] dat;
      we  = 1'($urandom_range(0, 1));
      ad  = AW'($urandom_range(0, 511)) | ((p == 1) ? AW'(10'h200) : AW'(0));
      dat = DW'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      access(p, we, ad, dat, 0);
    end
  endtask

  // ---------------- monitor: scoreboard pops and bus protocol ----------------
  logic          mon_en = 1'b0;
  logic [DW-1:0] a_hold, b_hold;
  int            oen_cnt, wen_cnt, n_pulses = 0, n_acks = 0;
  logic          prev_oen, prev_wen, prev_ce1n, prev_ce2, prev_dout_oe;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_dout;

  always @(negedge clk) begin
    txn_t t;
    if (!mon_en) begin
      oen_cnt = 0; wen_cnt = 0; prev_oen = 1'b1; prev_wen = 1'b1;
      a_hold = '0; b_hold = '0;
    end else begin
      if (!sram_oen && !sram_wen) fail_now("oen_wen_overlap");
      if (!sram_oen && sram_dout_oe) fail_now("dout_oe_during_read");
      if (!sram_oen) oen_cnt++;
      else if (oen_cnt != 0) begin
        check("oen_width", 32'(oen_cnt), 32'(RD)); n_pulses++; oen_cnt = 0;
      end
      if (!sram_wen) wen_cnt++;
      else if (wen_cnt != 0) begin
        check("wen_width", 32'(wen_cnt), 32'(WR)); n_pulses++; wen_cnt = 0;
      end
      if (!sram_oen || !sram_wen || !prev_oen || !prev_wen) begin
        check("strobe_ce", 32'({sram_ce1n, sram_ce2, prev_ce1n, prev_ce2}), 32'h5);
        check("strobe_addr", 32'(sram_addr), 32'(prev_addr));
      end
      if (!sram_wen || !prev_wen) begin
        check("wr_bus", 32'({sram_dout_oe, sram_dout}), 32'({1'b1, prev_dout}));
        check("wr_bus_prev_oe", 32'(prev_dout_oe), 32'd1);
      end
      if (a_ack && b_ack) fail_now("both_acks");
      if (a_ack) begin
        n_acks++; ack_port.push_back(0); ack_cyc.push_back(cyc);
        if (exp_a_q.size() == 0) fail_now("a_unexpected_ack");
        else begin
          t = exp_a_q.pop_front();
          check("a_sram_addr", 32'(sram_addr), 32'(t.addr));
          if (t.we) check("a_sram_dout", 32'(sram_dout), 32'(t.data));
          else begin
            check("a_rdata", 32'(a_rdata), 32'(t.data));
            a_hold = t.data;
          end
        end
      end else check("a_rdata_hold", 32'(a_rdata), 32'(a_hold));
      if (b_ack) begin
        n_acks++; ack_port.push_back(1); ack_cyc.push_back(cyc);
        if (exp_b_q.size() == 0) fail_now("b_unexpected_ack");
        else begin
          t = exp_b_q.pop_front();
          check("b_sram_addr", 32'(sram_addr), 32'(t.addr));
          if (t.we) check("b_sram_dout", 32'(sram_dout), 32'(t.data));
          else begin
            check("b_rdata", 32'(b_rdata), 32'(t.data));
            b_hold = t.data;
          end
        end
      end else check("b_rdata_hold", 32'(b_rdata), 32'(b_hold));
    end
    prev_oen = sram_oen; prev_wen = sram_wen; prev_ce1n = sram_ce1n; prev_ce2 = sram_ce2;
    prev_addr = sram_addr; prev_dout = sram_dout; prev_dout_oe = sram_dout_oe;
  end

  // ---------------- stimulus ----------------
  initial begin
    int base;
    bit ack_seen;
    bit wen_seen;
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_val(i);

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", 32'({sram_ce1n, sram_ce2, sram_oen, sram_wen, sram_dout_oe}), 32'b10110);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_dout", 32'(sram_dout), 32'd0);
    check("rst_acks", 32'({a_ack, b_ack}), 32'd0);
    check("rst_rdata", 32'({a_rdata, b_rdata}), 32'd0);
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;

    // A writes 0xA5 to 0x123, then reads it back
    access(0, 1'b1, 10'h123, 8'hA5, WR + 2);
    access(0, 1'b0, 10'h123, 8'h00, RD + 2);
    check("a_rdata_A5", 32'(a_rdata), 32'hA5);

    // Reset in the middle of a write; data written equals the current image
    // so the outcome of the aborted write does not matter.
    @(negedge clk);
    a_we = 1'b1; a_addr = 10'h3AB; a_wdata = ref_mem[10'h3AB]; a_req = 1'b1;
    wen_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!sram_wen) begin
        wen_seen = 1'b1;
        break;
      end
    end
    check("abort_wen_low", 32'(wen_seen), 32'd1);
    mon_en = 1'b0;
    reset  = 1'b1;
    @(posedge clk);
    #1;
    check("abort_ctrl", 32'({sram_wen, sram_ce1n, sram_dout_oe, sram_oen}), 32'b1101);
    check("abort_ack", 32'({a_ack, b_ack}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    a_req = 1'b0;
    ack_seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (a_ack || b_ack) ack_seen = 1'b1;
    end
    check("abort_no_ack", 32'(ack_seen), 32'd0);
    mon_en = 1'b1;

    // Simultaneous requests straight after reset: A wins, B waits one access
    base = ack_port.size();
    fork
      access(0, 1'b0, 10'h010, 8'h00, RD + 2);
      access(1, 1'b1, 10'h020, 8'h5A, (RD + 3) + (WR + 2));
    join
    @(negedge clk);
    #1;
    if (ack_port.size() >= base + 2) begin
      check("tie_first_A", 32'(ack_port[base]), 32'd0);
      check("tie_second_B", 32'(ack_port[base + 1]), 32'd1);
    end else fail_now("tie_ack_count");

    // Continuous contention: 8 reads alternating A,B with RD+3 cycle spacing
    base = ack_port.size();
    fork
      for (int i = 0; i < 4; i++) access(0, 1'b0, AW'($urandom_range(0, 511)), 8'h00, 0);
      for (int i = 0; i < 4; i++) access(1, 1'b0, AW'($urandom_range(512, 1023)), 8'h00, 0);
    join
    @(negedge clk);
    #1;
    if (ack_port.size() == base + 8) begin
      for (int i = 0; i < 8; i++) begin
        check("rr_order", 32'(ack_port[base + i]), 32'(i % 2));
        if (i > 0) check("rr_spacing", 32'(ack_cyc[base + i] - ack_cyc[base + i - 1]), 32'(RD + 3));
      end
    end else fail_now("rr_ack_count");

    // B reads the top and bottom addresses
    access(1, 1'b0, 10'h3FF, 8'h00, RD + 2);
    access(1, 1'b0, 10'h000, 8'h00, RD + 2);

    // Randomised traffic, ports confined to disjoint halves of the memory
    fork
      rand_port(0, 25);
      rand_port(1, 25);
    join

    repeat (5) @(negedge clk);
    check("a_queue_empty", 32'(exp_a_q.size()), 32'd0);
    check("b_queue_empty", 32'(exp_b_q.size()), 32'd0);
    check("pulse_per_ack", 32'(n_pulses), 32'(n_acks));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

endmodule
